arbitro_display_7segmentos: RTL and testbench
=============================================

ARBITRO_DISPLAY_7SEGMENTOS -- requirements
Module: arbitro_display_7segmentos

Interface
REQ-001 Parameter HOLD_CICLOS, default 100000000, minimum clock cycles an owner keeps the display once granted; legal range 1..2^27-1.
REQ-002 i_Reloj  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_Reset  input  1  reset, asynchronous, active-low.
REQ-004 i_Req  input  3  request per requester Rk, level, held high while Rk wants the display.
REQ-005 i_Datos_R0 / i_Datos_R1 / i_Datos_R2  input  16 each  four BCD/hex digits of Rk, bits [3:0] = digit 0.
REQ-006 o_Gnt  output  3  one-hot grant, at most one bit high.
REQ-007 o_Propietario  output  2  index of current owner, 2'd3 when none.
REQ-008 o_Valido  output  1  high while any requester owns the display.
REQ-009 o_Datos_0..o_Datos_3  output  4 each  registered digits for the display driver, o_Datos_k = owner bits [4k+3:4k].

Function
REQ-010 The block SHALL implement states LIBRE (no owner), OCUPADO (owner, hold counter running), EXPIRADO (owner, hold elapsed).
REQ-011 LIBRE: when any i_Req bit is high, the SHALL-granted requester is chosen round-robin and o_Gnt asserts on the next rising edge (1-cycle latency); state -> OCUPADO.
REQ-012 Round-robin order SHALL be last owner +1, +2, then last owner itself (mod 3); the last-owner pointer resets to 2 so R0 wins first.
REQ-013 The hold counter SHALL clear on every grant edge and increment each cycle in OCUPADO; at count HOLD_CICLOS-1 state -> EXPIRADO.
REQ-014 OCUPADO: owner keeps grant regardless of other requests while its i_Req is high.
REQ-015 EXPIRADO: if another i_Req bit is high, grant SHALL pass directly to the next round-robin requester on the next edge (no gap cycle), counter cleared, state -> OCUPADO; otherwise owner keeps grant indefinitely.
REQ-016 In OCUPADO or EXPIRADO, owner dropping i_Req SHALL release: if another request is pending that edge, grant passes to it (round-robin from owner) -> OCUPADO; else o_Gnt=0, o_Valido=0, -> LIBRE.
REQ-017 o_Datos_k SHALL load the granted requester's data on the grant edge and on every following edge while it owns the display.
REQ-018 In LIBRE o_Datos_k SHALL hold the last loaded value.
REQ-019 o_Valido SHALL equal (o_Gnt != 0); o_Propietario SHALL be consistent with o_Gnt on every cycle.
REQ-020 HOLD_CICLOS=1: EXPIRADO SHALL be entered one cycle after grant.
REQ-021 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-022 i_Reset low SHALL immediately (asynchronously) force: state LIBRE, o_Gnt=0, o_Valido=0, o_Propietario=2'd3, o_Datos_0..3=4'h0, counter=0, pointer=2.
REQ-023 Reset asserted mid-ownership SHALL drop the grant without completing the hold; after release, arbitration restarts as from power-up on the first rising edge.

Configuration
REQ-024 Macro ARBITRO_PRIORIDAD_R0_EN defined: R0 request while R1/R2 owns (OCUPADO or EXPIRADO) SHALL preempt on the next edge, counter cleared, ignoring hold; R0 itself is never preempted before its hold elapses.
REQ-025 Macro not defined: pure round-robin with hold per REQ-011..REQ-016; no preemption logic synthesized.

Verification (HOLD_CICLOS=4)
REQ-026 Assert i_Reset=0 with i_Req=3'b111 -> o_Gnt=0, o_Valido=0, o_Propietario=3, all o_Datos=0 immediately, no clock needed.
REQ-027 After reset, i_Req=3'b010, i_Datos_R1=16'h1234 -> next edge o_Gnt=3'b010, o_Datos_0..3=4,3,2,1, o_Valido=1.
REQ-028 After reset, i_Req=3'b101 held -> R0 granted 4 cycles, then o_Gnt=3'b100 with no gap, 4 cycles later back to 3'b001.
REQ-029 R1 owns, i_Req drops to 0 -> next edge o_Gnt=0, o_Propietario=3, o_Datos unchanged at 4,3,2,1.
REQ-030 Macro defined: R2 owns, R0 raises at hold cycle 1 -> next edge o_Gnt=3'b001; macro undefined: same stimulus -> switch only after cycle 4.
REQ-031 i_Reset pulsed low between edges while R2 owns -> outputs cleared asynchronously; i_Req=3'b100 still high -> first edge after release grants R2.

Source files
------------

// File: rtl/arbitro_display_7segmentos.sv
// Round-robin arbiter granting a shared 4-digit 7-segment display with a hold time.
// Optional R0 preemption: define ARBITRO_PRIORIDAD_R0_EN.
module arbitro_display_7segmentos #(
  parameter int HOLD_CICLOS = 100000000
) (
  input  logic        i_Reloj,
  input  logic        i_Reset,
  input  logic [2:0]  i_Req,
  input  logic [15:0] i_Datos_R0,
  input  logic [15:0] i_Datos_R1,
  input  logic [15:0] i_Datos_R2,
  output logic [2:0]  o_Gnt,
  output logic [1:0]  o_Propietario,
  output logic        o_Valido,
  output logic [3:0]  o_Datos_0,
  output logic [3:0]  o_Datos_1,
  output logic [3:0]  o_Datos_2,
  output logic [3:0]  o_Datos_3
);

  typedef enum logic [1:0] {
    LIBRE,
    OCUPADO,
    EXPIRADO
  } estado_t;

  localparam logic [26:0] HOLD_MAX = 27'(HOLD_CICLOS - 1);

  estado_t     estado_q, estado_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [1:0]  prop_q, prop_d;
  logic [1:0]  ultimo_q, ultimo_d;
  logic        valido_q, valido_d;
  logic [15:0] datos_q, datos_d;
  logic [26:0] cnt_q, cnt_d;

  logic [2:0]  sel;
  logic        grant_now;
  logic        owner_req;
  logic        expiro;

  function automatic logic [1:0] sig(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [2:0] oh(input logic [1:0] i);
    return 3'b001 << i;
  endfunction

  // Returns {found, index}: base+1, base+2, then base itself if incl.
  function automatic logic [2:0] elegir(
    input logic [2:0] req,
    input logic [1:0] base,
    input logic       incl
  );
    logic [1:0] a;
    logic [1:0] b;
    a = sig(base);
    b = sig(a);
    if (|(req & oh(a)))
      return {1'b1, a};
    else if (|(req & oh(b)))
      return {1'b1, b};
    else if (incl && |(req & oh(base)))
      return {1'b1, base};
    else
      return 3'b000;
  endfunction

  always_comb begin
    estado_d  = estado_q;
    gnt_d     = gnt_q;
    prop_d    = prop_q;
    ultimo_d  = ultimo_q;
    datos_d   = datos_q;
    cnt_d     = cnt_q;
    sel       = 3'b000;
    grant_now = 1'b0;
    owner_req = |(gnt_q & i_Req);
    expiro    = (estado_q == EXPIRADO) || (cnt_q == HOLD_MAX);

    unique case (estado_q)
      LIBRE: begin
        sel       = elegir(i_Req, ultimo_q, 1'b1);
        grant_now = sel[2];
      end
      OCUPADO, EXPIRADO: begin
        if (!owner_req) begin
          sel = elegir(i_Req, prop_q, 1'b0);
          grant_now = sel[2];
          if (!sel[2]) begin
            estado_d = LIBRE;
            gnt_d    = 3'b000;
            prop_d   = 2'd3;
          end
        end else if (expiro) begin
          sel = elegir(i_Req, prop_q, 1'b0);
          grant_now = sel[2];
          if (!sel[2])
            estado_d = EXPIRADO;
        end else begin
          cnt_d = cnt_q + 27'd1;
        end
      end
      default: estado_d = LIBRE;
    endcase

`ifdef ARBITRO_PRIORIDAD_R0_EN
    if (estado_q != LIBRE && prop_q != 2'd0 && i_Req[0]) begin
      sel       = 3'b100;
      grant_now = 1'b1;
    end
`endif

    if (grant_now) begin
      estado_d = OCUPADO;
      gnt_d    = oh(sel[1:0]);
      prop_d   = sel[1:0];
      ultimo_d = sel[1:0];
      cnt_d    = '0;
    end

    valido_d = |gnt_d;

    // Owner's digits are refreshed on every edge it holds the display.
    unique case (1'b1)
      gnt_d[0]: datos_d = i_Datos_R0;
      gnt_d[1]: datos_d = i_Datos_R1;
      gnt_d[2]: datos_d = i_Datos_R2;
      default:  datos_d = datos_q;
    endcase
  end

  always_ff @(posedge i_Reloj or negedge i_Reset) begin
    if (!i_Reset) begin
      estado_q <= LIBRE;
      gnt_q    <= 3'b000;
      prop_q   <= 2'd3;
      ultimo_q <= 2'd2;
      valido_q <= 1'b0;
      datos_q  <= '0;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      gnt_q    <= gnt_d;
      prop_q   <= prop_d;
      ultimo_q <= ultimo_d;
      valido_q <= valido_d;
      datos_q  <= datos_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_Gnt         = gnt_q;
  assign o_Propietario = prop_q;
  assign o_Valido      = valido_q;
  assign o_Datos_0     = datos_q[3:0];
  assign o_Datos_1     = datos_q[7:4];
  assign o_Datos_2     = datos_q[11:8];
  assign o_Datos_3     = datos_q[15:12];

endmodule

// File: tb/tb_arbitro_display_7segmentos.sv
// Directed bench for arbitro_display_7segmentos with HOLD_CICLOS=4.
// Expectations follow ARBITRO_PRIORIDAD_R0_EN when it is defined.
module tb_arbitro_display_7segmentos;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [15:0] d0, d1, d2;
  logic [2:0]  gnt;
  logic [1:0]  prop;
  logic        valido;
  logic [3:0]  q0, q1, q2, q3;

  int n_total;
  int n_bad;

  arbitro_display_7segmentos #(.HOLD_CICLOS(4)) dut (
    .i_Reloj      (clk),
    .i_Reset      (rst_n),
    .i_Req        (req),
    .i_Datos_R0   (d0),
    .i_Datos_R1   (d1),
    .i_Datos_R2   (d2),
    .o_Gnt        (gnt),
    .o_Propietario(prop),
    .o_Valido     (valido),
    .o_Datos_0    (q0),
    .o_Datos_1    (q1),
    .o_Datos_2    (q2),
    .o_Datos_3    (q3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 3'b000;
    repeat (2) tick();
    rst_n = 1'b1;
    req = 3'b111;
    tick();
    n_total++;
    if (gnt !== 3'b001) begin
      n_bad++;
      $display("FAIL first_grant gnt=%b exp=001", gnt);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (gnt !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_gnt gnt=%b exp=000", gnt);
    end
    n_total++;
    if (valido !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_valido got=%b exp=0", valido);
    end
    n_total++;
    if (prop !== 2'd3) begin
      n_bad++;
      $display("FAIL rst_prop got=%0d exp=3", prop);
    end
    n_total++;
    if ({q3, q2, q1, q0} !== 16'h0000) begin
      n_bad++;
      $display("FAIL rst_datos got=%h exp=0000", {q3, q2, q1, q0});
    end
    req = 3'b000;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req = 3'b010;
    tick();
    n_total++;
    if (gnt !== 3'b010) begin
      n_bad++;
      $display("FAIL r1_gnt gnt=%b exp=010", gnt);
    end
    n_total++;
    if (valido !== 1'b1 || prop !== 2'd1) begin
      n_bad++;
      $display("FAIL r1_own valido=%b prop=%0d exp=1/1", valido, prop);
    end
    n_total++;
    if ({q3, q2, q1, q0} !== 16'h1234) begin
      n_bad++;
      $display("FAIL r1_datos got=%h exp=1234", {q3, q2, q1, q0});
    end
    req = 3'b000;
    tick();
    n_total++;
    if (gnt !== 3'b000 || valido !== 1'b0) begin
      n_bad++;
      $display("FAIL rel_gnt gnt=%b valido=%b exp=000/0", gnt, valido);
    end
    n_total++;
    if (prop !== 2'd3) begin
      n_bad++;
      $display("FAIL rel_prop got=%0d exp=3", prop);
    end
    n_total++;
    if ({q3, q2, q1, q0} !== 16'h1234) begin
      n_bad++;
      $display("FAIL rel_datos got=%h exp=1234", {q3, q2, q1, q0});
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [9];
    exp_g = '{3'b001, 3'b001, 3'b001, 3'b001,
              3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
    pulse_reset();
    req = 3'b101;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_total++;
      if (gnt !== exp_g[i]) begin
        n_bad++;
        $display("FAIL rr_c%0d gnt=%b exp=%b", i, gnt, exp_g[i]);
      end
    end
  endtask

  task automatic test_expired_keep();
    req = 3'b001;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_total++;
      if (gnt !== 3'b001) begin
        n_bad++;
        $display("FAIL keep_c%0d gnt=%b exp=001", i, gnt);
      end
    end
    req = 3'b011;
    tick();
    n_total++;
    if (gnt !== 3'b010 || prop !== 2'd1) begin
      n_bad++;
      $display("FAIL exp_pass gnt=%b prop=%0d exp=010/1", gnt, prop);
    end
    req = 3'b000;
    tick();
  endtask

  task automatic test_preempt();
    logic [2:0] exp_g [3];
`ifdef ARBITRO_PRIORIDAD_R0_EN
    exp_g = '{3'b001, 3'b001, 3'b001};
`else
    exp_g = '{3'b100, 3'b100, 3'b001};
`endif
    pulse_reset();
    req = 3'b100;
    tick();
    n_total++;
    if (gnt !== 3'b100) begin
      n_bad++;
      $display("FAIL pre_r2 gnt=%b exp=100", gnt);
    end
    tick();
    req = 3'b101;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (gnt !== exp_g[i]) begin
        n_bad++;
        $display("FAIL pre_c%0d gnt=%b exp=%b", i, gnt, exp_g[i]);
      end
    end
    req = 3'b000;
    tick();
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    req = 3'b100;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (gnt !== 3'b000 || prop !== 2'd3 || valido !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_rst gnt=%b prop=%0d v=%b exp=000/3/0", gnt, prop, valido);
    end
    n_total++;
    if ({q3, q2, q1, q0} !== 16'h0000) begin
      n_bad++;
      $display("FAIL mid_datos got=%h exp=0000", {q3, q2, q1, q0});
    end
    rst_n = 1'b1;
    tick();
    n_total++;
    if (gnt !== 3'b100 || prop !== 2'd2) begin
      n_bad++;
      $display("FAIL mid_regrant gnt=%b prop=%0d exp=100/2", gnt, prop);
    end
    n_total++;
    if ({q3, q2, q1, q0} !== 16'h9abc) begin
      n_bad++;
      $display("FAIL mid_regrant_datos got=%h exp=9abc", {q3, q2, q1, q0});
    end
    req = 3'b000;
    tick();
  endtask

  task automatic test_drop_pass();
    pulse_reset();
    req = 3'b010;
    tick();
    tick();
    req = 3'b100;
    tick();
    n_total++;
    if (gnt !== 3'b100 || valido !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_pass gnt=%b v=%b exp=100/1", gnt, valido);
    end
    n_total++;
    if ({q3, q2, q1, q0} !== 16'h9abc) begin
      n_bad++;
      $display("FAIL drop_datos got=%h exp=9abc", {q3, q2, q1, q0});
    end
    d2 = 16'h0f0e;
    tick();
    n_total++;
    if ({q3, q2, q1, q0} !== 16'h0f0e) begin
      n_bad++;
      $display("FAIL follow_datos got=%h exp=0f0e", {q3, q2, q1, q0});
    end
    req = 3'b000;
    tick();
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    req     = 3'b000;
    d0      = 16'h5678;
    d1      = 16'h1234;
    d2      = 16'h9abc;
    test_reset();
    test_single();
    test_round_robin();
    test_expired_keep();
    test_preempt();
    test_reset_mid();
    test_drop_pass();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
